mem_access_stage: RTL and testbench

- MEM pipeline stage between the EX/MEM register and the MEM_WB register.
- Drives a variable-latency data-memory port with a req/gnt/rvalid handshake.
- Performs byte, half and word load/store lane steering and load sign-extension.
- Stalls the upstream pipeline and presents bubbles to MEM_WB while an access is outstanding.

---
 rtl/mem_access_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/gnt/rvalid data-memory port, lane steering, load extension, stall/bubble.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned H/W accesses without issuing a request.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  Funct3_in,
  input  logic [31:0] ALU_Result_in,
  input  logic [31:0] WriteData_in,
  input  logic [4:0]  RdAddr_in,
  input  logic        Reg_w_in,
  input  logic        Mem_to_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        bus_err,
  output logic        misalign,
  output logic        Reg_w_out,
  output logic        Mem_to_reg_out,
  output logic [31:0] ALU_Result_out,
  output logic [31:0] MemReadData_out,
  output logic [4:0]  RdAddr_out
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RD, DONE} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic        bus_err_q, bus_err_d;
  logic        misalign_q, misalign_d;

  logic        is_b, is_h, is_unsigned, mem_op, is_store, trap;
  logic        req_c, stall_c, timeout;
  logic [1:0]  a;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign a           = ALU_Result_in[1:0];
  assign mem_op      = MemRead_in | MemWrite_in;
  assign is_store    = MemWrite_in;
  assign is_b        = (Funct3_in == 3'b000) || (Funct3_in == 3'b100);
  assign is_h        = (Funct3_in == 3'b001) || (Funct3_in == 3'b101);
  assign is_unsigned = Funct3_in[2] & ~Funct3_in[1];

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = mem_op & ((is_h & a[0]) | (~is_b & ~is_h & (a != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteData_in;
    if (is_b) begin
      dmem_be    = 4'b0001 << a;
      dmem_wdata = {4{WriteData_in[7:0]}};
    end else if (is_h) begin
      dmem_be    = 4'b0011 << {a[1], 1'b0};
      dmem_wdata = {2{WriteData_in[15:0]}};
    end
  end

  assign byte_sel = dmem_rdata[{a, 3'b000} +: 8];
  assign half_sel = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    load_ext = dmem_rdata;
    if (is_b)      load_ext = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
    else if (is_h) load_ext = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
  end

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    bus_err_d  = 1'b0;
    misalign_d = 1'b0;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_op) begin
          stall_c = 1'b1;
          if (trap) begin
            state_d    = DONE;
            misalign_d = 1'b1;
          end else begin
            req_c = 1'b1;
            if (dmem_gnt) state_d = is_store ? DONE : WAIT_RD;
            else          state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        if (dmem_gnt) begin
          state_d = is_store ? DONE : WAIT_RD;
          cnt_d   = cnt_q + 8'd1;
        end else if (timeout) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
          if (!is_store) buf_d = ERR_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_RD: begin
        stall_c = 1'b1;
        if (dmem_rvalid) begin
          state_d = DONE;
          buf_d   = load_ext;
        end else if (timeout) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
          buf_d     = ERR_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      buf_q      <= '0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end

  // Gating with rst_n drops the request and stall the instant reset asserts.
  assign dmem_req        = req_c & rst_n;
  assign stall           = stall_c & rst_n;
  assign dmem_we         = MemWrite_in;
  assign dmem_addr       = {ALU_Result_in[31:2], 2'b00};
  assign bus_err         = bus_err_q;
  assign misalign        = misalign_q;
  assign Reg_w_out       = Reg_w_in & ~stall_c & ~misalign_q;
  assign Mem_to_reg_out  = Mem_to_reg_in & ~stall_c;
  assign ALU_Result_out  = ALU_Result_in;
  assign RdAddr_out      = RdAddr_in;
  assign MemReadData_out = (state_q == DONE) ? buf_q : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage (TIMEOUT_CYCLES=4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead_in = 0, MemWrite_in = 0;
  logic [2:0]  Funct3_in = '0;
  logic [31:0] ALU_Result_in = '0, WriteData_in = '0;
  logic [4:0]  RdAddr_in = '0;
  logic        Reg_w_in = 0, Mem_to_reg_in = 0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 0, dmem_rvalid = 0;
  logic [31:0] dmem_rdata = '0;
  logic        stall, bus_err, misalign, Reg_w_out, Mem_to_reg_out;
  logic [31:0] ALU_Result_out, MemReadData_out;
  logic [4:0]  RdAddr_out;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Funct3_in(Funct3_in),
    .ALU_Result_in(ALU_Result_in), .WriteData_in(WriteData_in), .RdAddr_in(RdAddr_in),
    .Reg_w_in(Reg_w_in), .Mem_to_reg_in(Mem_to_reg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall(stall), .bus_err(bus_err), .misalign(misalign),
    .Reg_w_out(Reg_w_out), .Mem_to_reg_out(Mem_to_reg_out), .ALU_Result_out(ALU_Result_out),
    .MemReadData_out(MemReadData_out), .RdAddr_out(RdAddr_out)
  );

  typedef struct {
    logic        reg_w;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        chk_data;
    logic [4:0]  rd;
    logic        berr;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic inst_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle an instruction is presented with stall low, MEM_WB latches.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && inst_active && !stall) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: got unexpected completion expected none");
      end else begin
        e = sb.pop_front();
        chk("reg_w", 32'(Reg_w_out), 32'(e.reg_w));
        chk("mem_to_reg", 32'(Mem_to_reg_out), 32'(e.m2r));
        chk("alu_out", ALU_Result_out, e.alu);
        chk("rd_out", 32'(RdAddr_out), 32'(e.rd));
        chk("bus_err", 32'(bus_err), 32'(e.berr));
        chk("misalign", 32'(misalign), 32'(e.mis));
        if (e.chk_data) chk("rdata_out", MemReadData_out, e.rdata);
      end
    end
  end

  task automatic op(input string nm, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rda,
                    input logic rw, input logic m2r, input int gnt_c, input int rv_c,
                    input logic [31:0] rdata, input int exp_stall, input logic [3:0] exp_be,
                    input logic [31:0] exp_wd, input exp_t e, input int exp_req);
    int cyc = 0;
    int stalls = 0;
    int reqs = 0;
    bit done = 0;
    sb.push_back(e);
    @(posedge clk); #1;
    MemRead_in = rd_en; MemWrite_in = wr_en; Funct3_in = f3; ALU_Result_in = addr;
    WriteData_in = wd; RdAddr_in = rda; Reg_w_in = rw; Mem_to_reg_in = m2r;
    inst_active = 1'b1;
    while (!done && cyc < 40) begin
      dmem_gnt    = (cyc == gnt_c);
      dmem_rvalid = (cyc == rv_c);
      dmem_rdata  = (cyc == rv_c) ? rdata : 32'h0;
      @(negedge clk);
      if (dmem_req) reqs++;
      if (dmem_req && dmem_gnt) begin
        chk({nm, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({nm, "_we"}, 32'(dmem_we), 32'(wr_en));
        if (wr_en) begin
          chk({nm, "_be"}, 32'(dmem_be), 32'(exp_be));
          chk({nm, "_wdata"}, dmem_wdata, exp_wd);
        end
      end
      if (stall) begin
        stalls++;
        chk({nm, "_bubble"}, 32'({Mem_to_reg_out, Reg_w_out}), 32'h0);
      end else begin
        done = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
    MemRead_in = 0; MemWrite_in = 0; Reg_w_in = 0; Mem_to_reg_in = 0;
    inst_active = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_hang: got stall after 40 cycles expected completion", nm);
    end
    chk({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    if (exp_req >= 0) chk({nm, "_req_cycles"}, 32'(reqs), 32'(exp_req));
    @(negedge clk);
    chk({nm, "_pulse_end"}, 32'({bus_err, misalign, stall}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'({stall, dmem_req, bus_err, misalign, Reg_w_out}), 32'h0);
    chk("rst_rdata", MemReadData_out, 32'h0);

    op("alu", 0, 0, 3'b000, 32'h1234, 0, 5, 1, 0, -1, -1, 0, 0, 4'h0, 0,
       '{1'b1, 1'b0, 32'h1234, 32'h0, 1'b1, 5'd5, 1'b0, 1'b0}, 0);
    op("lb", 1, 0, 3'b000, 32'h103, 0, 7, 1, 1, 0, 2, 32'h80AABBCC, 3, 4'h0, 0,
       '{1'b1, 1'b1, 32'h103, 32'hFFFFFF80, 1'b1, 5'd7, 1'b0, 1'b0}, 1);
    op("sh", 0, 1, 3'b001, 32'h2, 32'h0000BEEF, 0, 0, 0, 0, -1, 0, 1, 4'b1100, 32'hBEEFBEEF,
       '{1'b0, 1'b0, 32'h2, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0}, 1);
    op("lw_to_gnt", 1, 0, 3'b010, 32'h40, 0, 9, 1, 1, -1, -1, 0, 5, 4'h0, 0,
       '{1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 5'd9, 1'b1, 1'b0}, 5);
    op("lbu", 1, 0, 3'b100, 32'h101, 0, 3, 1, 1, 0, 1, 32'h1234F6AB, 2, 4'h0, 0,
       '{1'b1, 1'b1, 32'h101, 32'h000000F6, 1'b1, 5'd3, 1'b0, 1'b0}, 1);
    op("lh", 1, 0, 3'b001, 32'h2, 0, 4, 1, 1, 1, 3, 32'h80017FFF, 4, 4'h0, 0,
       '{1'b1, 1'b1, 32'h2, 32'hFFFF8001, 1'b1, 5'd4, 1'b0, 1'b0}, 2);
    op("lhu", 1, 0, 3'b101, 32'h0, 0, 6, 1, 1, 0, 1, 32'h1234ABCD, 2, 4'h0, 0,
       '{1'b1, 1'b1, 32'h0, 32'h0000ABCD, 1'b1, 5'd6, 1'b0, 1'b0}, 1);
    op("sb", 0, 1, 3'b000, 32'h1, 32'h000000A5, 0, 0, 0, 2, -1, 0, 3, 4'b0010, 32'hA5A5A5A5,
       '{1'b0, 1'b0, 32'h1, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0}, 3);
    op("sw", 0, 1, 3'b010, 32'h8, 32'h11223344, 0, 0, 0, 1, -1, 0, 2, 4'b1111, 32'h11223344,
       '{1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0}, 2);
    op("lh_to_rd", 1, 0, 3'b001, 32'h6, 0, 10, 1, 1, 0, -1, 0, 5, 4'h0, 0,
       '{1'b1, 1'b1, 32'h6, 32'hDEADBEEF, 1'b1, 5'd10, 1'b1, 1'b0}, 1);
    op("f3_011_as_w", 1, 0, 3'b011, 32'hE, 0, 11, 1, 1, 0, 1, 32'hCAFEF00D, 2, 4'h0, 0,
       '{1'b1, 1'b1, 32'hE, 32'hCAFEF00D, 1'b1, 5'd11, 1'b0, 1'b0}, 1);
    op("rv_with_gnt", 1, 0, 3'b000, 32'h0, 0, 12, 1, 1, 0, 0, 32'h0000007F, 5, 4'h0, 0,
       '{1'b1, 1'b1, 32'h0, 32'hDEADBEEF, 1'b1, 5'd12, 1'b1, 1'b0}, 1);
`ifdef MEM_MISALIGN_TRAP_EN
    op("lw_misal", 1, 0, 3'b010, 32'h101, 0, 4, 1, 1, -1, -1, 0, 1, 4'h0, 0,
       '{1'b0, 1'b1, 32'h101, 32'h0, 1'b0, 5'd4, 1'b0, 1'b1}, 0);
`else
    op("lw_unal", 1, 0, 3'b010, 32'h101, 0, 4, 1, 1, 0, 1, 32'h55667788, 2, 4'h0, 0,
       '{1'b1, 1'b1, 32'h101, 32'h55667788, 1'b1, 5'd4, 1'b0, 1'b0}, 1);
`endif

    // Reset while a load waits for rvalid; a late rvalid must be ignored.
    @(posedge clk); #1;
    MemRead_in = 1; Funct3_in = 3'b010; ALU_Result_in = 32'h200; Reg_w_in = 1; dmem_gnt = 0;
    @(negedge clk);
    chk("rst_pre_req", 32'(dmem_req), 32'h1);
    @(posedge clk); #1 dmem_gnt = 1;
    @(posedge clk); #1 dmem_gnt = 0;
    @(posedge clk); #1;
    chk("rst_wait_rd_stall", 32'(stall), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({stall, dmem_req}), 32'h0);
    MemRead_in = 0; Reg_w_in = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    chk("rst_late_rv_stall", 32'({stall, dmem_req}), 32'h0);
    @(posedge clk); #1 dmem_rvalid = 0;
    @(negedge clk);
    chk("rst_late_rv_data", MemReadData_out, 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
